// File: rtl/sbus_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// sbus_if : bundles the SBUS receiver line and the decoded frame outputs.
//
//   rx_in       raw SBUS line driven by the board pin (asynchronous to clk)
//   ch_data     CH_NUM x 11-bit channel words, channel i at [11*i+10:11*i]
//   ch17, ch18  digital channels (flags byte bits 0 and 1)
//   frame_lost  flags byte bit 2 of the last good frame
//   failsafe    flags byte bit 3 of the last good frame
//   frame_valid one-cycle pulse per accepted frame
//   err_cnt     saturating count of rejected frames
//
// Modports:
//   master : line source / frame consumer side (drives rx_in)
//   slave  : the decoder (samples rx_in, drives the decoded outputs)
// ---------------------------------------------------------------------------
interface sbus_if #(
    parameter int CH_NUM = 16
);
    logic                 rx_in;
    logic [CH_NUM*11-1:0] ch_data;
    logic                 ch17;
    logic                 ch18;
    logic                 frame_lost;
    logic                 failsafe;
    logic                 frame_valid;
    logic [7:0]           err_cnt;

    modport master (
        output rx_in,
        input  ch_data, ch17, ch18, frame_lost, failsafe, frame_valid, err_cnt
    );

    modport slave (
        input  rx_in,
        output ch_data, ch17, ch18, frame_lost, failsafe, frame_valid, err_cnt
    );
endinterface

// File: rtl/sbus_frame_decoder.sv
// ---------------------------------------------------------------------------
// sbus_frame_decoder : SBUS (100 kbaud, 8E2, normally inverted) receiver.
//
// An oversampled byte receiver feeds a frame FSM that hunts for an idle gap,
// checks the 0x0F header, collects 22 payload bytes plus the flags byte into
// shadow registers, and on a valid footer copies everything to the outputs in
// a single cycle so consumers never see a partially updated frame.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   sbus_if.slave : rx_in in, decoded channels/flags/status out
//
// Parameters:
//   CLK_DIV   system clocks per SBUS bit (>= 16)
//   CH_NUM    channels exported (1..16)
//   INVERT    1 = line is inverted (standard SBUS), 0 = used as-is
//   GAP_BITS  idle bit times required before a header is accepted
//
// Build option:
//   SBUS_PARITY_CHECK_EN  when defined, even parity is checked on every byte
//                         and a parity failure rejects the frame.
// ---------------------------------------------------------------------------
module sbus_frame_decoder #(
    parameter int CLK_DIV  = 500,
    parameter int CH_NUM   = 16,
    parameter int INVERT   = 1,
    parameter int GAP_BITS = 30
) (
    input  logic   clk,
    input  logic   rst,
    sbus_if.slave  bus
);

    localparam int CNT_W   = $clog2(CLK_DIV);
    localparam int GAP_CYC = GAP_BITS * CLK_DIV;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);
    localparam int CH_W    = CH_NUM * 11;

    // Raw pin level when the line is idle; the synchroniser resets to it so
    // reset release never looks like a start-bit edge.
    localparam logic RAW_IDLE = (INVERT != 0) ? 1'b0 : 1'b1;

`ifdef SBUS_PARITY_CHECK_EN
    localparam logic PAR_CHECK = 1'b1;
`else
    localparam logic PAR_CHECK = 1'b0;
`endif

    // Byte receiver states
    localparam logic [2:0] B_IDLE  = 3'd0;
    localparam logic [2:0] B_START = 3'd1;
    localparam logic [2:0] B_DATA  = 3'd2;
    localparam logic [2:0] B_PAR   = 3'd3;
    localparam logic [2:0] B_STOP1 = 3'd4;
    localparam logic [2:0] B_STOP2 = 3'd5;

    // Frame FSM states
    localparam logic [2:0] F_HUNT  = 3'd0;
    localparam logic [2:0] F_HDR   = 3'd1;
    localparam logic [2:0] F_PAY   = 3'd2;
    localparam logic [2:0] F_FLAG  = 3'd3;
    localparam logic [2:0] F_FOOT  = 3'd4;

    // ---------------- input synchroniser / edge detect ----------------
    logic rx_s1_q, rx_s2_q, line_prev_q;
    logic line, fall;

    assign line = (INVERT != 0) ? ~rx_s2_q : rx_s2_q;
    assign fall = line_prev_q & ~line;

    // ---------------- byte receiver ----------------
    logic [2:0]       b_state_q, b_state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             sample;
    logic             byte_rdy;
    logic             rx_ferr;

    assign sample = (bit_cnt_q == '0);

    // Stop bit 2 is judged directly from the line in its sample cycle.
    assign rx_ferr = ferr_q | ~line;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        b_state_d = b_state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        byte_rdy  = 1'b0;

        // Mid-bit sampling: reload a full bit period after every sample.
        if (b_state_q != B_IDLE) begin
            bit_cnt_d = sample ? CNT_W'(CLK_DIV - 1) : bit_cnt_q - 1'b1;
        end

        case (b_state_q)
            B_IDLE: begin
                if (fall) begin
                    b_state_d = B_START;
                    bit_cnt_d = CNT_W'(CLK_DIV / 2);
                end
            end
            B_START: begin
                if (sample) begin
                    if (line) begin
                        b_state_d = B_IDLE;     // glitch, not a real start bit
                    end else begin
                        b_state_d = B_DATA;
                        bit_idx_d = 3'd0;
                        ferr_d    = 1'b0;
                    end
                end
            end
            B_DATA: begin
                if (sample) begin
                    shreg_d   = {line, shreg_q[7:1]};   // LSB first
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) b_state_d = B_PAR;
                end
            end
            B_PAR: begin
                if (sample) begin
                    // Even parity: data XOR parity must be 0.
                    perr_d    = PAR_CHECK & (^{shreg_q, line});
                    b_state_d = B_STOP1;
                end
            end
            B_STOP1: begin
                if (sample) begin
                    ferr_d    = ~line;
                    b_state_d = B_STOP2;
                end
            end
            B_STOP2: begin
                if (sample) begin
                    byte_rdy = 1'b1;
                    // An edge coinciding with this sample is the next start bit.
                    if (fall) begin
                        b_state_d = B_START;
                        bit_cnt_d = CNT_W'(CLK_DIV / 2);
                    end else begin
                        b_state_d = B_IDLE;
                    end
                end
            end
            default: b_state_d = B_IDLE;
        endcase
    end

    // ---------------- frame FSM ----------------
    logic [2:0]       f_state_q, f_state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [4:0]       pay_idx_q, pay_idx_d;
    logic [175:0]     payload_q, payload_d;
    logic [3:0]       flags_sh_q, flags_sh_d;
    logic [CH_W-1:0]  ch_data_q, ch_data_d;
    logic [3:0]       flags_q, flags_d;
    logic             frame_valid_q, frame_valid_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             reject;
    logic             byte_bad;

    assign byte_bad = rx_ferr | perr_q;

    always_comb begin
        f_state_d     = f_state_q;
        gap_cnt_d     = gap_cnt_q;
        pay_idx_d     = pay_idx_q;
        payload_d     = payload_q;
        flags_sh_d    = flags_sh_q;
        ch_data_d     = ch_data_q;
        flags_d       = flags_q;
        frame_valid_d = 1'b0;
        err_cnt_d     = err_cnt_q;
        reject        = 1'b0;

        case (f_state_q)
            F_HUNT: begin
                // Bytes seen while hunting are ignored; any activity restarts
                // the idle measurement.
                if (b_state_q == B_IDLE && line) begin
                    if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                        f_state_d = F_HDR;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end else begin
                    gap_cnt_d = '0;
                end
            end
            F_HDR: begin
                if (byte_rdy) begin
                    if (byte_bad || shreg_q != 8'h0F) begin
                        reject = 1'b1;
                    end else begin
                        f_state_d = F_PAY;
                        pay_idx_d = 5'd0;
                    end
                end
            end
            F_PAY: begin
                if (byte_rdy) begin
                    if (byte_bad) begin
                        reject = 1'b1;
                    end else begin
                        // After 22 shifts payload byte k sits at [8k+7:8k].
                        payload_d = {shreg_q, payload_q[175:8]};
                        pay_idx_d = pay_idx_q + 5'd1;
                        if (pay_idx_q == 5'd21) f_state_d = F_FLAG;
                    end
                end
            end
            F_FLAG: begin
                if (byte_rdy) begin
                    if (byte_bad) begin
                        reject = 1'b1;
                    end else begin
                        flags_sh_d = shreg_q[3:0];
                        f_state_d  = F_FOOT;
                    end
                end
            end
            F_FOOT: begin
                if (byte_rdy) begin
                    if (!byte_bad && (shreg_q[3:0] == 4'h0 || shreg_q[3:0] == 4'h4)) begin
                        ch_data_d     = payload_q[CH_W-1:0];
                        flags_d       = flags_sh_q;
                        frame_valid_d = 1'b1;
                        f_state_d     = F_HDR;   // back-to-back frames need no gap
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            default: f_state_d = F_HUNT;
        endcase

        if (reject) begin
            f_state_d = F_HUNT;
            gap_cnt_d = '0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q       <= RAW_IDLE;
            rx_s2_q       <= RAW_IDLE;
            line_prev_q   <= 1'b1;
            b_state_q     <= B_IDLE;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            perr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            f_state_q     <= F_HUNT;
            gap_cnt_q     <= '0;
            pay_idx_q     <= '0;
            payload_q     <= '0;
            flags_sh_q    <= '0;
            ch_data_q     <= '0;
            flags_q       <= 4'b1100;    // failsafe and frame_lost until a good frame
            frame_valid_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            rx_s1_q       <= bus.rx_in;
            rx_s2_q       <= rx_s1_q;
            line_prev_q   <= line;
            b_state_q     <= b_state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            perr_q        <= perr_d;
            ferr_q        <= ferr_d;
            f_state_q     <= f_state_d;
            gap_cnt_q     <= gap_cnt_d;
            pay_idx_q     <= pay_idx_d;
            payload_q     <= payload_d;
            flags_sh_q    <= flags_sh_d;
            ch_data_q     <= ch_data_d;
            flags_q       <= flags_d;
            frame_valid_q <= frame_valid_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign bus.ch_data     = ch_data_q;
    assign bus.ch17        = flags_q[0];
    assign bus.ch18        = flags_q[1];
    assign bus.frame_lost  = flags_q[2];
    assign bus.failsafe    = flags_q[3];
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_sbus_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_sbus_frame_decoder : directed SBUS frames with a scoreboard.
// The stimulus thread pushes the expected output set for every frame that
// must be accepted; the monitor pops and compares on each frame_valid pulse.
// Rejected / ignored frames are checked by looking at err_cnt and the
// unchanged outputs after the frame has been sent.
// ---------------------------------------------------------------------------
module tb_sbus_frame_decoder;

    localparam int CLK_DIV  = 16;
    localparam int CH_NUM   = 16;
    localparam int GAP_BITS = 30;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sbus_if #(.CH_NUM(CH_NUM)) bus ();

    sbus_frame_decoder #(
        .CLK_DIV  (CLK_DIV),
        .CH_NUM   (CH_NUM),
        .INVERT   (1),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [175:0] ch;
        logic [3:0]   flags;
        logic [7:0]   err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (bus.frame_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_frame_valid", bus.frame_valid, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("ch_data",    bus.ch_data,    mon_e.ch);
                    check("ch17",       bus.ch17,       mon_e.flags[0]);
                    check("ch18",       bus.ch18,       mon_e.flags[1]);
                    check("frame_lost", bus.frame_lost, mon_e.flags[2]);
                    check("failsafe",   bus.failsafe,   mon_e.flags[3]);
                    check("err_cnt",    bus.err_cnt,    mon_e.err);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #(1_500_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- line driver ----------------
    task automatic put_bit(input logic b);
        bus.rx_in = ~b;                       // inverted SBUS line
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        bus.rx_in = 1'b0;
        repeat (n * CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit flip_par);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(b[i]);
        put_bit((^b) ^ flip_par);
        put_bit(!bad_stop);
        put_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [175:0] pay,
                              input logic [7:0] flags, input logic [7:0] foot,
                              input int bad_stop_idx, input int flip_par_idx);
        send_byte(hdr, 1'b0, 1'b0);
        for (int k = 0; k < 22; k++)
            send_byte(pay[8*k +: 8], k == bad_stop_idx, k == flip_par_idx);
        send_byte(flags, 1'b0, 1'b0);
        send_byte(foot, 1'b0, 1'b0);
    endtask

    function automatic logic [175:0] make_pay(input int mode);
        logic [175:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       p[11*i +: 11] = 11'h400;
                1:       p[11*i +: 11] = 11'(100 * i + 1);
                default: p[11*i +: 11] = (i % 2 == 1) ? 11'h7FF : 11'h000;
            endcase
        end
        return p;
    endfunction

    task automatic expect_frame(input logic [175:0] pay, input logic [7:0] flags, input logic [7:0] err);
        exp_t e;
        e.ch    = pay;
        e.flags = flags[3:0];
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * CLK_DIV && sb_q.size() != 0; i++) @(negedge clk);
        check(name, sb_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ch_data"},     bus.ch_data,     0);
        check({tag, "_ch17"},        bus.ch17,        0);
        check({tag, "_ch18"},        bus.ch18,        0);
        check({tag, "_frame_lost"},  bus.frame_lost,  1);
        check({tag, "_failsafe"},    bus.failsafe,    1);
        check({tag, "_frame_valid"}, bus.frame_valid, 0);
        check({tag, "_err_cnt"},     bus.err_cnt,     0);
    endtask

    // ---------------- stimulus ----------------
    logic [175:0] p_1024, p_ramp, p_alt;
    logic [7:0]   exp_err;

    initial begin
        p_1024  = make_pay(0);
        p_ramp  = make_pay(1);
        p_alt   = make_pay(2);
        exp_err = 8'd0;

        rst       = 1'b1;
        bus.rx_in = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Frame 1: all channels 1024, flags 0x00, footer 0x00
        idle_bits(GAP_BITS + 2);
        expect_frame(p_1024, 8'h00, exp_err);
        send_frame(8'h0F, p_1024, 8'h00, 8'h00, -1, -1);
        wait_drain("f1_accepted");
        check("f1_ch0",  bus.ch_data[10:0],    11'h400);
        check("f1_ch15", bus.ch_data[175:165], 11'h400);

        // Frame 2 back-to-back: ramp, flags 0x0B, footer 0x04
        expect_frame(p_ramp, 8'h0B, exp_err);
        send_frame(8'h0F, p_ramp, 8'h0B, 8'h04, -1, -1);
        wait_drain("f2_accepted");
        check("f2_ch1",  bus.ch_data[21:11],   11'd101);
        check("f2_ch15", bus.ch_data[175:165], 11'd1501);

        // Frame 3: bad header 0x0E
        idle_bits(GAP_BITS + 2);
        send_frame(8'h0E, p_alt, 8'h00, 8'h00, -1, -1);
        exp_err = 8'd1;
        check("hdr_err_cnt",   bus.err_cnt, exp_err);
        check("hdr_unchanged", bus.ch_data, p_ramp);
        check("hdr_failsafe",  bus.failsafe, 1);

        // Frame 4: good frame with no gap after the reject is ignored
        send_frame(8'h0F, p_alt, 8'h04, 8'h14, -1, -1);
        check("nogap_unchanged", bus.ch_data, p_ramp);
        check("nogap_err_cnt",   bus.err_cnt, exp_err);

        // Frame 5: after a full gap, accepted (footer 0x14 masks to 0x04)
        idle_bits(GAP_BITS + 2);
        expect_frame(p_alt, 8'h04, exp_err);
        send_frame(8'h0F, p_alt, 8'h04, 8'h14, -1, -1);
        wait_drain("f5_accepted");

        // Frame 6: stop bit 0 in payload byte 5
        idle_bits(GAP_BITS + 2);
        send_frame(8'h0F, p_1024, 8'h00, 8'h00, 5, -1);
        exp_err = 8'd2;
        check("ferr_err_cnt",   bus.err_cnt, exp_err);
        check("ferr_unchanged", bus.ch_data, p_alt);

        // Frame 7: next valid frame accepted
        idle_bits(GAP_BITS + 2);
        expect_frame(p_1024, 8'h08, exp_err);
        send_frame(8'h0F, p_1024, 8'h08, 8'h00, -1, -1);
        wait_drain("f7_accepted");

        // Frame 8: parity bit of payload byte 10 flipped
        idle_bits(GAP_BITS + 2);
`ifdef SBUS_PARITY_CHECK_EN
        send_frame(8'h0F, p_ramp, 8'h03, 8'h00, -1, 10);
        exp_err = exp_err + 8'd1;
        check("perr_err_cnt",   bus.err_cnt, exp_err);
        check("perr_unchanged", bus.ch_data, p_1024);
`else
        expect_frame(p_ramp, 8'h03, exp_err);
        send_frame(8'h0F, p_ramp, 8'h03, 8'h00, -1, 10);
        wait_drain("perr_ignored_accepted");
`endif

        // Frame 9: bad footer 0x08
        idle_bits(GAP_BITS + 2);
        send_frame(8'h0F, p_alt, 8'h00, 8'h08, -1, -1);
        exp_err = exp_err + 8'd1;
        check("foot_err_cnt", bus.err_cnt, exp_err);

        // Frame 10: good frame after the bad footer
        idle_bits(GAP_BITS + 2);
        expect_frame(p_ramp, 8'h00, exp_err);
        send_frame(8'h0F, p_ramp, 8'h00, 8'h04, -1, -1);
        wait_drain("f10_accepted");

        // Reset in the middle of payload byte 12
        idle_bits(GAP_BITS + 2);
        send_byte(8'h0F, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) send_byte(p_1024[8*k +: 8], 1'b0, 1'b0);
        put_bit(1'b0);
        for (int i = 0; i < 4; i++) put_bit(p_1024[96 + i]);
        rst       = 1'b1;
        bus.rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        exp_err = 8'd0;
        @(negedge clk);
        check_reset_outputs("midrst");

        // Frame one bit time after reset release: ignored
        idle_bits(1);
        send_frame(8'h0F, p_1024, 8'h00, 8'h00, -1, -1);
        check("postrst_ch_data",  bus.ch_data,  0);
        check("postrst_failsafe", bus.failsafe, 1);
        check("postrst_err_cnt",  bus.err_cnt,  exp_err);

        // Next frame after a full gap: accepted
        idle_bits(GAP_BITS + 2);
        expect_frame(p_ramp, 8'h0B, exp_err);
        send_frame(8'h0F, p_ramp, 8'h0B, 8'h00, -1, -1);
        wait_drain("final_accepted");

        idle_bits(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
